// File: rtl/softmax_max_sub.sv
// Streaming max-subtract stage: buffers one vector, tracks its maximum, then emits (x - max) >>> SHIFT per element.
// Optional output clamping is enabled by defining SOFTMAX_MAX_SUB_SAT_EN; otherwise the result wraps to OUT_WIDTH.
module softmax_max_sub #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 32,
    parameter int LANES     = 8,
    parameter int SHIFT     = 2,
    parameter int OUT_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [LANES*BIT_WIDTH-1:0]    i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [LANES*OUT_WIDTH-1:0]    o_data,
    output logic                          o_last,
    output logic signed [BIT_WIDTH-1:0]   o_max
);

    localparam int BEATS  = N / LANES;
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LVLS   = $clog2(LANES);
    localparam int TREE_P = 1 << LVLS;
    // Difference width: one bit wider than the input so it never wraps, and wide
    // enough to compare against the most-negative output value.
    localparam int EW     = (OUT_WIDTH + 1 > BIT_WIDTH + 1) ? OUT_WIDTH + 1 : BIT_WIDTH + 1;
    localparam logic signed [BIT_WIDTH-1:0] MAX_INIT = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic {
        ST_LOAD,
        ST_EMIT
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               in_cnt_q, in_cnt_d;
    logic [CW-1:0]               out_cnt_q, out_cnt_d;
    logic signed [BIT_WIDTH-1:0] max_q, max_d;
    logic signed [BIT_WIDTH-1:0] beat_buf_q [BEATS][LANES];
    logic signed [BIT_WIDTH-1:0] beat_buf_d [BEATS][LANES];

    logic signed [BIT_WIDTH-1:0] in_lane [LANES];
    logic signed [BIT_WIDTH-1:0] beat_max;
    logic                        accept;
    logic                        out_fire;

    genvar gi, gj;

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_in
            assign in_lane[gi] = i_data[gi*BIT_WIDTH +: BIT_WIDTH];
        end
    endgenerate

    // Balanced max tree; padding leaves hold the most-negative value so they never win.
    generate
        for (gi = 0; gi <= LVLS; gi++) begin : g_lvl
            localparam int W = TREE_P >> gi;
            logic signed [BIT_WIDTH-1:0] node [W];
            for (gj = 0; gj < W; gj++) begin : g_node
                if (gi == 0) begin : g_leaf
                    if (gj < LANES) begin : g_real
                        assign node[gj] = in_lane[gj];
                    end else begin : g_pad
                        assign node[gj] = MAX_INIT;
                    end
                end else begin : g_cmp
                    assign node[gj] = (g_lvl[gi-1].node[2*gj] > g_lvl[gi-1].node[2*gj+1])
                                      ? g_lvl[gi-1].node[2*gj] : g_lvl[gi-1].node[2*gj+1];
                end
            end
        end
    endgenerate

    assign beat_max = g_lvl[LVLS].node[0];

    assign o_ready  = (state_q == ST_LOAD) && !i_rst;
    assign o_valid  = (state_q == ST_EMIT);
    assign accept   = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;

    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        max_d      = max_q;
        beat_buf_d = beat_buf_q;

        if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                beat_buf_d[in_cnt_q][l] = in_lane[l];
            end
            // First beat restarts the running max so nothing leaks from the previous vector.
            if (in_cnt_q == '0) begin
                max_d = beat_max;
            end else begin
                max_d = (beat_max > max_q) ? beat_max : max_q;
            end
            if (in_cnt_q == LAST_BEAT) begin
                in_cnt_d = '0;
                state_d  = ST_EMIT;
            end else begin
                in_cnt_d = in_cnt_q + CW'(1);
            end
        end

        if (out_fire) begin
            if (out_cnt_q == LAST_BEAT) begin
                out_cnt_d = '0;
                state_d   = ST_LOAD;
            end else begin
                out_cnt_d = out_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_LOAD;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            max_q     <= MAX_INIT;
            for (int b = 0; b < BEATS; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    beat_buf_q[b][l] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            max_q      <= max_d;
            beat_buf_q <= beat_buf_d;
        end
    end

`ifdef SOFTMAX_MAX_SUB_SAT_EN
    localparam logic signed [EW-1:0] OUT_MIN_EXT =
        {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`endif

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_out
            logic signed [BIT_WIDTH-1:0] elem;
            logic signed [EW-1:0]        diff;
            logic [OUT_WIDTH-1:0]        lane_out;

            assign elem = beat_buf_q[out_cnt_q][gi];
            assign diff = {{(EW-BIT_WIDTH){elem[BIT_WIDTH-1]}}, elem}
                        - {{(EW-BIT_WIDTH){max_q[BIT_WIDTH-1]}}, max_q};
`ifdef SOFTMAX_MAX_SUB_SAT_EN
            logic signed [EW-1:0] shifted;
            assign shifted  = diff >>> SHIFT;
            // The difference is never positive, so only the negative bound needs a clamp.
            assign lane_out = (shifted < OUT_MIN_EXT) ? OUT_MIN_EXT[OUT_WIDTH-1:0]
                                                      : shifted[OUT_WIDTH-1:0];
`else
            assign lane_out = OUT_WIDTH'(diff >>> SHIFT);
`endif
            assign o_data[gi*OUT_WIDTH +: OUT_WIDTH] = o_valid ? lane_out : '0;
        end
    endgenerate

    assign o_last = o_valid && (out_cnt_q == LAST_BEAT);
    assign o_max  = o_valid ? max_q : '0;

endmodule

// File: tb/tb_softmax_max_sub.sv
// Scoreboard bench for softmax_max_sub: default-width and 12-bit-output instances share one stimulus stream.
module tb_softmax_max_sub;

    localparam int BW    = 16;
    localparam int N     = 32;
    localparam int LANES = 8;
    localparam int SHIFT = 2;
    localparam int OW    = 16;
    localparam int OW12  = 12;
    localparam int BEATS = N / LANES;

    typedef int vec_t [N];
    typedef struct {
        logic [LANES*OW-1:0]   d16;
        logic [LANES*OW12-1:0] d12;
        logic signed [BW-1:0]  mx;
        logic                  last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_valid = 1'b0;
    logic i_ready = 1'b0;
    logic [LANES*BW-1:0] i_data = '0;

    logic o_ready, o_valid, o_last;
    logic [LANES*OW-1:0] o_data;
    logic signed [BW-1:0] o_max;
    logic o_ready12, o_valid12, o_last12;
    logic [LANES*OW12-1:0] o_data12;
    logic signed [BW-1:0] o_max12;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = -10;
    int ready_mode = 0;   // 0: always 1, 1: random, 2: always 0, 3: driven by the main sequence

    softmax_max_sub #(.BIT_WIDTH(BW), .N(N), .LANES(LANES), .SHIFT(SHIFT), .OUT_WIDTH(OW)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last), .o_max(o_max)
    );

    softmax_max_sub #(.BIT_WIDTH(BW), .N(N), .LANES(LANES), .SHIFT(SHIFT), .OUT_WIDTH(OW12)) u_dut12 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready12), .i_data(i_data),
        .o_valid(o_valid12), .i_ready(i_ready), .o_data(o_data12), .o_last(o_last12), .o_max(o_max12)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: narrow an exact integer result to w bits, clamping only when saturation is built in.
    function automatic int narrow(input int d, input int w);
        int lo;
        lo = -(1 << (w - 1));
`ifdef SOFTMAX_MAX_SUB_SAT_EN
        if (d < lo) d = lo;
`endif
        return d;
    endfunction

    task automatic push_expected(input vec_t v);
        int mx;
        mx = v[0];
        for (int i = 1; i < N; i++) if (v[i] > mx) mx = v[i];
        for (int b = 0; b < BEATS; b++) begin
            exp_t e;
            e.d16 = '0;
            e.d12 = '0;
            for (int l = 0; l < LANES; l++) begin
                int d, t16, t12;
                d   = (v[b*LANES+l] - mx) >>> SHIFT;
                t16 = narrow(d, OW);
                t12 = narrow(d, OW12);
                e.d16[l*OW +: OW]     = t16[OW-1:0];
                e.d12[l*OW12 +: OW12] = t12[OW12-1:0];
            end
            e.mx   = BW'(mx);
            e.last = (b == BEATS - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [LANES*BW-1:0] d);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data  = d;
        @(negedge clk);
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got o_ready=0 expected 1 within 200 cycles");
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    function automatic logic [LANES*BW-1:0] pack_beat(input vec_t v, input int b);
        logic [LANES*BW-1:0] p;
        for (int l = 0; l < LANES; l++) begin
            int t;
            t = v[b*LANES+l];
            p[l*BW +: BW] = t[BW-1:0];
        end
        return p;
    endfunction

    task automatic send_vec(input vec_t v, input int gap_max);
        push_expected(v);
        for (int b = 0; b < BEATS; b++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            send_beat(pack_beat(v, b));
        end
    endtask

    task automatic pulse_reset(input int cycles);
        rst     = 1'b1;
        i_valid = 1'b0;
        exp_q.delete();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !o_ready) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", {255'd0, exp_q.size() == 0 && o_ready}, 256'd1);
    endtask

    function automatic vec_t rand_vec(input int kind);
        vec_t v;
        for (int i = 0; i < N; i++) begin
            if (kind == 0) v[i] = int'($urandom_range(0, 65535)) - 32768;
            else           v[i] = int'($urandom_range(0, 7)) * 1000 - 3000;
        end
        return v;
    endfunction

    // Ready generator
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: i_ready = 1'b1;
            1: i_ready = 1'($urandom_range(0, 1));
            2: i_ready = 1'b0;
            default: ;
        endcase
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each output handshake
    initial begin
        logic                  held;
        logic                  prev_valid;
        logic [LANES*OW-1:0]   hd16;
        logic [LANES*OW12-1:0] hd12;
        logic signed [BW-1:0]  hmx;
        logic                  hlast;
        exp_t                  e;
        held = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_o_ready", {255'd0, o_ready | o_ready12}, 256'd0);
                chk("rst_o_valid", {255'd0, o_valid | o_valid12}, 256'd0);
                chk("rst_o_last", {255'd0, o_last | o_last12}, 256'd0);
                chk("rst_o_data", {128'd0, o_data}, {128'd0, 128'd0});
                chk("rst_o_max", {240'd0, o_max}, 256'd0);
                held = 1'b0;
                prev_valid = 1'b0;
            end else begin
                chk("ready_vs_valid", {255'd0, o_ready}, {255'd0, !o_valid});
                chk("lockstep_valid", {255'd0, o_valid12}, {255'd0, o_valid});
                if (held) begin
                    chk("hold_valid", {255'd0, o_valid}, 256'd1);
                    chk("hold_data", {128'd0, o_data}, {128'd0, hd16});
                    chk("hold_data12", {160'd0, o_data12}, {160'd0, hd12});
                    chk("hold_last", {255'd0, o_last}, {255'd0, hlast});
                    chk("hold_max", {240'd0, o_max}, {240'd0, hmx});
                end
                if (o_valid && !prev_valid) begin
                    chk("latency", 256'(cyc), 256'(acc_cyc + 1));
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %h expected no output", o_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("o_data", {128'd0, o_data}, {128'd0, e.d16});
                        chk("o_data12", {160'd0, o_data12}, {160'd0, e.d12});
                        chk("o_max", {240'd0, o_max}, {240'd0, e.mx});
                        chk("o_max12", {240'd0, o_max12}, {240'd0, e.mx});
                        chk("o_last", {254'd0, o_last, o_last12}, {254'd0, e.last, e.last});
                    end
                end
                held  = o_valid && !i_ready;
                hd16  = o_data;
                hd12  = o_data12;
                hmx   = o_max;
                hlast = o_last;
                prev_valid = o_valid;
            end
        end
    end

    // Stimulus
    initial begin
        vec_t v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Uniform vector: every output is zero
        foreach (v[i]) v[i] = 16384;
        send_vec(v, 0);
        wait_idle();

        // Extremes: no wrap in the 16-bit build, narrow build wraps or clamps
        foreach (v[i]) v[i] = 0;
        v[5]  = 32767;
        v[20] = -32768;
        send_vec(v, 0);
        wait_idle();

        // Backpressure 1,0,0,1 at the start of EMIT
        ready_mode = 3;
        i_ready = 1'b0;
        send_vec(rand_vec(0), 0);
        i_ready = 1'b1;
        @(posedge clk); #1; i_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; i_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        wait_idle();

        // Back-to-back vectors: the second max must restart from its own data
        foreach (v[i]) v[i] = int'($urandom_range(0, 9000)) - 4000;
        v[7] = 5000;
        send_vec(v, 0);
        foreach (v[i]) v[i] = -100;
        send_vec(v, 0);
        wait_idle();

        // Reset mid-LOAD, then mid-EMIT, each followed by a fresh vector
        v = rand_vec(0);
        send_beat(pack_beat(v, 0));
        send_beat(pack_beat(v, 1));
        pulse_reset(2);
        send_vec(rand_vec(1), 0);
        wait_idle();
        ready_mode = 2;
        send_vec(rand_vec(0), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        pulse_reset(1);
        ready_mode = 0;
        send_vec(rand_vec(0), 0);
        wait_idle();

        // Randomized traffic with input gaps and random backpressure
        ready_mode = 1;
        for (int k = 0; k < 20; k++) begin
            send_vec(rand_vec(k % 2), 2);
        end
        wait_idle();
        ready_mode = 0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
